// File: rtl/usb_fs_arb_pkg.sv
// Shared types and constants for the USB full-speed endpoint arbiters.
// Holds the arbiter FSM state encoding and the priority mode selectors.
package usb_fs_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

  localparam logic ARB_MODE_RR    = 1'b0;
  localparam logic ARB_MODE_FIXED = 1'b1;

  // The index ports are at least one bit wide, even for a single requester.
  function automatic int unsigned arb_idx_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/usb_fs_out_arb_rr_if.sv
// OUT data-path arbitration bundle between the OUT endpoints and the arbiter.
// The master modport is the arbiter side; the slave modport is the endpoint side.
interface usb_fs_out_arb_rr_if
  import usb_fs_arb_pkg::*;
#(
  parameter int NUM_OUT_EPS = 1
);
  localparam int IDX_W = arb_idx_w(NUM_OUT_EPS);

  logic [NUM_OUT_EPS-1:0] out_ep_req;
  logic [NUM_OUT_EPS-1:0] out_ep_grant;
  logic                   out_ep_grant_valid;
  logic [IDX_W-1:0]       out_ep_grant_idx;
  logic                   out_ep_timeout;

  modport master (
    input  out_ep_req,
    output out_ep_grant,
    output out_ep_grant_valid,
    output out_ep_grant_idx,
    output out_ep_timeout
  );

  modport slave (
    output out_ep_req,
    input  out_ep_grant,
    input  out_ep_grant_valid,
    input  out_ep_grant_idx,
    input  out_ep_timeout
  );

endinterface

// File: rtl/usb_fs_rr_pick.sv
// Combinational rotate-priority picker: first set bit of `eligible` found by
// searching upward from start_idx with wrap (from 0 in fixed mode).
module usb_fs_rr_pick
  import usb_fs_arb_pkg::*;
#(
  parameter  int NUM_REQ = 1,
  localparam int IDX_W   = arb_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   start_idx,
  input  logic               mode,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any
);

  // One spare bit so base + offset cannot overflow before the wrap.
  localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] base_s;
  logic [IDX_W:0] pos_s;

  // Walk the requesters in rotated order and keep the first eligible one.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    pos_s      = '0;
    base_s     = (mode == ARB_MODE_FIXED) ? '0 : {1'b0, start_idx};
    for (int off = 0; off < NUM_REQ; off++) begin
      pos_s = base_s + (IDX_W+1)'(off);
      if (pos_s >= NUM_W) begin
        pos_s = pos_s - NUM_W;
      end else begin
        pos_s = pos_s;
      end
      if (!any && eligible[pos_s[IDX_W-1:0]]) begin
        any                         = 1'b1;
        winner[pos_s[IDX_W-1:0]]    = 1'b1;
        winner_idx                  = pos_s[IDX_W-1:0];
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/usb_fs_out_arb_rr.sv
// Locked-grant arbiter for the shared USB FS OUT data path (round-robin or fixed).
// Optional hold-timeout watchdog enabled by defining USB_ARB_TIMEOUT_EN.
module usb_fs_out_arb_rr
  import usb_fs_arb_pkg::*;
#(
  parameter int NUM_OUT_EPS     = 1,
  parameter int PRIORITY_MODE   = 0,
  parameter int MAX_HOLD_CYCLES = 1024
) (
  input logic                clk,
  input logic                reset,
  usb_fs_out_arb_rr_if.master bus
);

  localparam int               IDX_W    = arb_idx_w(NUM_OUT_EPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT_EPS - 1);
  localparam logic             MODE     = (PRIORITY_MODE == 1) ? ARB_MODE_FIXED : ARB_MODE_RR;

  arb_state_e             state_r, state_nx_s;
  logic [NUM_OUT_EPS-1:0] grant_r, grant_nx_s;
  logic [IDX_W-1:0]       grant_idx_r, idx_nx_s;
  logic [IDX_W-1:0]       last_idx_r, last_nx_s;
  logic                   valid_r;
  logic                   timeout_r, timeout_nx_s;

  logic [NUM_OUT_EPS-1:0] mask_s, eligible_s, pick_onehot_s, mask_set_s;
  logic [IDX_W-1:0]       start_s, pick_idx_s;
  logic                   pick_any_s, hold_expired_s, hold_clr_s, hold_inc_s;

  assign eligible_s = bus.out_ep_req & ~mask_s;
  assign start_s    = (last_idx_r == LAST_IDX) ? '0 : last_idx_r + IDX_W'(1);

  usb_fs_rr_pick #(.NUM_REQ(NUM_OUT_EPS)) u_pick (
    .eligible   (eligible_s),
    .start_idx  (start_s),
    .mode       (MODE),
    .winner     (pick_onehot_s),
    .winner_idx (pick_idx_s),
    .any        (pick_any_s)
  );

  // Next-state and next-output decode; a release always passes through IDLE.
  always_comb begin
    state_nx_s   = state_r;
    grant_nx_s   = grant_r;
    idx_nx_s     = grant_idx_r;
    last_nx_s    = last_idx_r;
    timeout_nx_s = 1'b0;
    hold_clr_s   = 1'b0;
    hold_inc_s   = 1'b0;
    mask_set_s   = '0;
    case (state_r)
      ARB_IDLE: begin
        if (pick_any_s) begin
          state_nx_s = ARB_GRANTED;
          grant_nx_s = pick_onehot_s;
          idx_nx_s   = pick_idx_s;
          hold_clr_s = 1'b1;
        end else begin
          state_nx_s = ARB_IDLE;
          grant_nx_s = '0;
          idx_nx_s   = '0;
        end
      end
      ARB_GRANTED: begin
        if (!bus.out_ep_req[grant_idx_r]) begin
          state_nx_s = ARB_IDLE;
          grant_nx_s = '0;
          idx_nx_s   = '0;
          last_nx_s  = grant_idx_r;
        end else if (hold_expired_s) begin
          state_nx_s   = ARB_IDLE;
          grant_nx_s   = '0;
          idx_nx_s     = '0;
          last_nx_s    = grant_idx_r;
          timeout_nx_s = 1'b1;
          mask_set_s   = grant_r;
        end else begin
          hold_inc_s = 1'b1;
        end
      end
      default: begin
        state_nx_s = ARB_IDLE;
        grant_nx_s = '0;
        idx_nx_s   = '0;
      end
    endcase
  end

  // State and registered outputs; reset skips any release bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ARB_IDLE;
      grant_r     <= '0;
      grant_idx_r <= '0;
      last_idx_r  <= LAST_IDX;
      valid_r     <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      grant_r     <= grant_nx_s;
      grant_idx_r <= idx_nx_s;
      last_idx_r  <= last_nx_s;
      valid_r     <= |grant_nx_s;
      timeout_r   <= timeout_nx_s;
    end
  end

`ifdef USB_ARB_TIMEOUT_EN
  localparam int                HOLD_W    = $clog2(MAX_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD_CYCLES - 1);

  logic [HOLD_W-1:0]      hold_cnt_r;
  logic [NUM_OUT_EPS-1:0] mask_r;

  // Hold counter per grant; a revoked endpoint stays masked until its req drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_r <= '0;
      mask_r     <= '0;
    end else begin
      if (hold_clr_s) begin
        hold_cnt_r <= '0;
      end else if (hold_inc_s) begin
        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
      mask_r <= (mask_r & bus.out_ep_req) | mask_set_s;
    end
  end

  assign mask_s         = mask_r;
  assign hold_expired_s = (hold_cnt_r == HOLD_LAST);
`else
  logic unused_cfg_s;

  assign mask_s         = '0;
  assign hold_expired_s = 1'b0;
  assign unused_cfg_s   = ^{hold_clr_s, hold_inc_s, mask_set_s, 32'(MAX_HOLD_CYCLES)};
`endif

  assign bus.out_ep_grant       = grant_r;
  assign bus.out_ep_grant_valid = valid_r;
  assign bus.out_ep_grant_idx   = grant_idx_r;
  assign bus.out_ep_timeout     = timeout_r;

endmodule
